// File: rtl/fb_arb_pkg.sv
// Frame-buffer port arbiter shared types: FSM states, read-tag owner/tag
// bundle and default bus widths for the 640x480 RGB565 frame buffer.
package fb_arb_pkg;

    localparam int FB_ADDR_W = 19;
    localparam int FB_DATA_W = 16;

    typedef enum logic [1:0] {
        IDLE,
        VGA_RUN,
        CE_SLOT
    } arb_state_e;

    typedef enum logic {
        OWN_VGA,
        OWN_CE
    } owner_e;

    typedef struct packed {
        logic   valid;
        owner_e owner;
    } tag_t;

    localparam tag_t TAG_NONE = '{valid: 1'b0, owner: OWN_VGA};

endpackage

// File: rtl/fb_arb_if.sv
// Handshake bundle between the VGA fetch path, the convolution engine,
// the frame-buffer RAM and the arbiter. slave = arbiter side,
// master = requester/RAM side (testbench or surrounding logic).
interface fb_arb_if
    import fb_arb_pkg::*;
#(
    parameter int ADDR_W = FB_ADDR_W,
    parameter int DATA_W = FB_DATA_W
);

    logic              vga_req;
    logic [ADDR_W-1:0] vga_addr;
    logic              vga_gnt;
    logic              vga_rvalid;
    logic [DATA_W-1:0] vga_rdata;

    logic              ce_req;
    logic              ce_we;
    logic [ADDR_W-1:0] ce_addr;
    logic [DATA_W-1:0] ce_wdata;
    logic              ce_gnt;
    logic              ce_rvalid;
    logic [DATA_W-1:0] ce_rdata;

    logic [ADDR_W-1:0] mem_addr;
    logic              mem_we;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    modport slave (
        input  vga_req, vga_addr,
        output vga_gnt, vga_rvalid, vga_rdata,
        input  ce_req, ce_we, ce_addr, ce_wdata,
        output ce_gnt, ce_rvalid, ce_rdata,
        output mem_addr, mem_we, mem_wdata,
        input  mem_rdata
    );

    modport master (
        output vga_req, vga_addr,
        input  vga_gnt, vga_rvalid, vga_rdata,
        output ce_req, ce_we, ce_addr, ce_wdata,
        input  ce_gnt, ce_rvalid, ce_rdata,
        input  mem_addr, mem_we, mem_wdata,
        output mem_rdata
    );

endinterface

// File: rtl/fb_rd_tag_pipe.sv
// Read-return tag shift register, DEPTH stages, asynchronously cleared.
// Ports: clk, reset_n, push_i (tag of this cycle's grant), tag_o (oldest).
module fb_rd_tag_pipe
    import fb_arb_pkg::*;
#(
    parameter int DEPTH = 3
) (
    input  logic clk,
    input  logic reset_n,
    input  tag_t push_i,
    output tag_t tag_o
);

    tag_t pipe_q [DEPTH];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                pipe_q[i] <= TAG_NONE;
            end
        end else begin
            pipe_q[0] <= push_i;
            for (int i = 1; i < DEPTH; i++) begin
                pipe_q[i] <= pipe_q[i-1];
            end
        end
    end

    assign tag_o = pipe_q[DEPTH-1];

endmodule

// File: rtl/fb_port_arbiter.sv
// Single-port frame-buffer arbiter: VGA priority with bounded runs, CE r/w.
// Ports: clk, reset_n, bus (fb_arb_if.slave). Macro FB_ARB_STATS_EN adds
// ce_wait_max / vga_stall_cnt statistics outputs.
module fb_port_arbiter
    import fb_arb_pkg::*;
#(
    parameter int ADDR_W      = FB_ADDR_W,
    parameter int DATA_W      = FB_DATA_W,
    parameter int RD_LAT      = 2,
    parameter int MAX_VGA_RUN = 8
) (
    input  logic        clk,
    input  logic        reset_n,
`ifdef FB_ARB_STATS_EN
    output logic [15:0] ce_wait_max,
    output logic [31:0] vga_stall_cnt,
`endif
    fb_arb_if.slave     bus
);

    localparam logic [7:0] MAX_RUN = 8'(MAX_VGA_RUN);

    arb_state_e        state_q;
    logic [7:0]        run_cnt_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic              mem_we_q;
    logic [DATA_W-1:0] mem_wdata_q;

    logic vga_gnt;
    logic ce_gnt;
    tag_t push;
    tag_t tag_out;
    logic vga_rv;
    logic ce_rv;

    // Grants are combinational; gated by reset so every output is quiet
    // the moment reset is asserted.
    always_comb begin
        vga_gnt = 1'b0;
        ce_gnt  = 1'b0;
        unique case (state_q)
            VGA_RUN: begin
                vga_gnt = bus.vga_req &&
                          (run_cnt_q < MAX_RUN || !bus.ce_req);
                ce_gnt  = bus.ce_req &&
                          (run_cnt_q == MAX_RUN || !bus.vga_req);
            end
            default: begin
                vga_gnt = bus.vga_req;
                ce_gnt  = bus.ce_req && !bus.vga_req;
            end
        endcase
        vga_gnt = vga_gnt && reset_n;
        ce_gnt  = ce_gnt && reset_n;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            run_cnt_q   <= '0;
            mem_addr_q  <= '0;
            mem_we_q    <= 1'b0;
            mem_wdata_q <= '0;
        end else begin
            mem_we_q <= 1'b0;
            if (vga_gnt) begin
                state_q    <= VGA_RUN;
                mem_addr_q <= bus.vga_addr;
                if (state_q != VGA_RUN) begin
                    run_cnt_q <= 8'd1;
                end else if (run_cnt_q != MAX_RUN) begin
                    run_cnt_q <= run_cnt_q + 8'd1;
                end
            end else if (ce_gnt) begin
                state_q     <= CE_SLOT;
                run_cnt_q   <= '0;
                mem_addr_q  <= bus.ce_addr;
                mem_we_q    <= bus.ce_we;
                mem_wdata_q <= bus.ce_wdata;
            end else begin
                state_q   <= IDLE;
                run_cnt_q <= '0;
            end
        end
    end

    // Writes push an invalid tag so the slot still advances in lockstep.
    assign push.valid = vga_gnt || (ce_gnt && !bus.ce_we);
    assign push.owner = vga_gnt ? OWN_VGA : OWN_CE;

    // Address is registered one cycle, RAM adds RD_LAT: RD_LAT+1 stages.
    fb_rd_tag_pipe #(
        .DEPTH (RD_LAT + 1)
    ) u_tag_pipe (
        .clk     (clk),
        .reset_n (reset_n),
        .push_i  (push),
        .tag_o   (tag_out)
    );

    assign vga_rv = tag_out.valid && (tag_out.owner == OWN_VGA);
    assign ce_rv  = tag_out.valid && (tag_out.owner == OWN_CE);

    assign bus.vga_gnt    = vga_gnt;
    assign bus.ce_gnt     = ce_gnt;
    assign bus.vga_rvalid = vga_rv;
    assign bus.ce_rvalid  = ce_rv;
    assign bus.vga_rdata  = vga_rv ? bus.mem_rdata : '0;
    assign bus.ce_rdata   = ce_rv ? bus.mem_rdata : '0;
    assign bus.mem_addr   = mem_addr_q;
    assign bus.mem_we     = mem_we_q;
    assign bus.mem_wdata  = mem_wdata_q;

`ifdef FB_ARB_STATS_EN
    logic [15:0] ce_wait_q;
    logic [15:0] ce_wait_d;
    logic [15:0] ce_wait_max_q;
    logic [31:0] vga_stall_q;

    always_comb begin
        ce_wait_d = '0;
        if (bus.ce_req && !ce_gnt) begin
            ce_wait_d = (ce_wait_q == 16'hFFFF) ? ce_wait_q
                                                : ce_wait_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ce_wait_q     <= '0;
            ce_wait_max_q <= '0;
            vga_stall_q   <= '0;
        end else begin
            ce_wait_q <= ce_wait_d;
            if (ce_wait_d > ce_wait_max_q) begin
                ce_wait_max_q <= ce_wait_d;
            end
            if (bus.vga_req && !vga_gnt && vga_stall_q != 32'hFFFF_FFFF) begin
                vga_stall_q <= vga_stall_q + 32'd1;
            end
        end
    end

    assign ce_wait_max   = ce_wait_max_q;
    assign vga_stall_cnt = vga_stall_q;
`endif

endmodule
